rp_scope_axi_wr_arb: RTL and testbench

//  Shares one AXI3 HP write port among NUM_CH scope acquisition channels.

---
 rtl/rp_axi_arb_pkg.sv | 19 +
 rtl/rp_id_fifo.sv | 49 ++++
 rtl/rp_scope_axi_wr_arb.sv | 170 +++++++++++++++++
 tb/tb_rp_scope_axi_wr_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_axi_arb_pkg.sv
// rtl/rp_axi_arb_pkg.sv - shared types and round-robin pick for the scope AXI write arbiter
package rp_axi_arb_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [1:0] BRESP_OKAY = 2'b00;
    localparam int         MAX_CH     = 4;

    // First requester at or above ptr, wrapping; unused upper request bits must be zero.
    function automatic logic [1:0] rr_pick(input logic [MAX_CH-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/rp_id_fifo.sv
// rtl/rp_id_fifo.sv - small sync FIFO of channel ids awaiting a B response
module rp_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rp_scope_axi_wr_arb.sv
// rtl/rp_scope_axi_wr_arb.sv - round-robin arbiter sharing one AXI3 write port among scope channels
module rp_scope_axi_wr_arb
    import rp_axi_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int LEN_W     = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic                    axi_clk_i,
    input  logic                    axi_rst_i,
    input  logic [NUM_CH-1:0]       req_i,
    input  logic [NUM_CH*AW-1:0]    req_addr_i,
    input  logic [NUM_CH*LEN_W-1:0] req_len_i,
    output logic [NUM_CH-1:0]       gnt_o,
    input  logic [NUM_CH*DW-1:0]    ch_dat_i,
    input  logic [NUM_CH*DW/8-1:0]  ch_strb_i,
    output logic [NUM_CH-1:0]       ch_rd_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       err_o,
    output logic                    busy_o,
    output logic [AW-1:0]           axi_awaddr_o,
    output logic [LEN_W-1:0]        axi_awlen_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [DW-1:0]           axi_wdata_o,
    output logic [DW/8-1:0]         axi_wstrb_o,
    output logic                    axi_wlast_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    input  logic                    axi_bvalid_i,
    input  logic [1:0]              axi_bresp_i,
    output logic                    axi_bready_o
);
    localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            state, state_nxt;
    logic [1:0]        id, rr_ptr, pick, b_id;
    logic [IDW-1:0]    b_id_raw;
    logic [AW-1:0]     addr_q;
    logic [LEN_W-1:0]  len_q, cnt;
    logic [MAX_CH-1:0] req_pad, gnt4, rd4, done4, err4;
    logic              fifo_full, fifo_empty, aw_hs, w_hs, b_hs, last, start;

    logic [AW-1:0]     addr_arr [MAX_CH];
    logic [LEN_W-1:0]  len_arr  [MAX_CH];
    logic [DW-1:0]     dat_arr  [MAX_CH];
    logic [DW/8-1:0]   strb_arr [MAX_CH];

    // Pad to MAX_CH so the arbiter and muxes see a fixed 2-bit channel index.
    for (genvar c = 0; c < MAX_CH; c++) begin : g_unpack
        if (c < NUM_CH) begin : g_live
            assign req_pad[c]  = req_i[c];
            assign addr_arr[c] = req_addr_i[c*AW +: AW];
            assign len_arr[c]  = req_len_i[c*LEN_W +: LEN_W];
            assign dat_arr[c]  = ch_dat_i[c*DW +: DW];
            assign strb_arr[c] = ch_strb_i[c*(DW/8) +: DW/8];
        end else begin : g_pad
            assign req_pad[c]  = 1'b0;
            assign addr_arr[c] = '0;
            assign len_arr[c]  = '0;
            assign dat_arr[c]  = '0;
            assign strb_arr[c] = '0;
        end
    end

    assign pick  = rr_pick(req_pad, rr_ptr);
    assign start = (state == IDLE) && (|req_pad) && !fifo_full;
    assign aw_hs = (state == ADDR) && axi_awready_i;
    assign w_hs  = (state == DATA) && axi_wready_i;
    assign last  = (cnt == len_q);
    assign b_hs  = axi_bvalid_i && !fifo_empty;
    assign b_id  = 2'(b_id_raw);

    rp_id_fifo #(.DEPTH(MAX_OUTST), .W(IDW)) u_id_fifo (
        .clk       (axi_clk_i),
        .rst       (axi_rst_i),
        .push      (aw_hs),
        .push_data (id[IDW-1:0]),
        .pop       (b_hs),
        .pop_data  (b_id_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state  <= IDLE;
            id     <= '0;
            rr_ptr <= '0;
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                id     <= pick;
                addr_q <= addr_arr[pick];
                len_q  <= len_arr[pick];
            end
            if (aw_hs) cnt <= '0;
            if (w_hs) begin
                cnt <= cnt + 1'b1;
                if (last) rr_ptr <= (id == 2'(NUM_CH - 1)) ? 2'd0 : id + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        axi_awvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        gnt4          = '0;
        rd4           = '0;
        case (state)
            IDLE: if (start) state_nxt = ADDR;
            ADDR: begin
                axi_awvalid_o = 1'b1;
                if (axi_awready_i) begin
                    gnt4[id]  = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                axi_wvalid_o = 1'b1;
                if (axi_wready_i) begin
                    rd4[id] = 1'b1;
                    if (last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done4 = '0;
        err4  = '0;
        if (b_hs) begin
            done4[b_id] = 1'b1;
            err4[b_id]  = (axi_bresp_i != BRESP_OKAY);
        end
    end

    assign gnt_o        = gnt4[NUM_CH-1:0];
    assign ch_rd_o      = rd4[NUM_CH-1:0];
    assign done_o       = done4[NUM_CH-1:0];
    assign err_o        = err4[NUM_CH-1:0];
    assign busy_o       = (state != IDLE) || !fifo_empty;
    assign axi_awaddr_o = addr_q;
    assign axi_awlen_o  = len_q;
    assign axi_wdata_o  = (state == DATA) ? dat_arr[id] : '0;
    assign axi_wstrb_o  = (state == DATA) ? strb_arr[id] : '0;
    assign axi_wlast_o  = (state == DATA) && last;
    assign axi_bready_o = !fifo_empty;

    // A burst must not cross a 4 KB page; payloads hold while the slave stalls.
    logic [31:0] page_end;
    assign page_end = 32'(addr_q[11:0]) + (32'(len_q) + 32'd1) * 32'(DW / 8);

    assert property (@(posedge axi_clk_i) disable iff (axi_rst_i)
        axi_awvalid_o |-> page_end <= 32'd4096);
    assert property (@(posedge axi_clk_i) disable iff (axi_rst_i)
        axi_awvalid_o && !axi_awready_i |=> axi_awvalid_o && $stable(axi_awaddr_o) && $stable(axi_awlen_o));
    assert property (@(posedge axi_clk_i) disable iff (axi_rst_i)
        axi_wvalid_o && !axi_wready_i |=> axi_wvalid_o && $stable(axi_wdata_o) && $stable(axi_wstrb_o) && $stable(axi_wlast_o));
    assert property (@(posedge axi_clk_i) disable iff (axi_rst_i)
        axi_bvalid_i |-> !fifo_empty);

endmodule

// File: tb/tb_rp_scope_axi_wr_arb.sv
// tb/tb_rp_scope_axi_wr_arb.sv - directed self-checking bench for rp_scope_axi_wr_arb
module tb_rp_scope_axi_wr_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] addr_v;
    logic [15:0]  len_v;
    logic [255:0] dat_v;
    logic [31:0]  strb_v;
    logic [3:0]   gnt, ch_rd, done, err;
    logic         busy;
    logic [31:0]  awaddr;
    logic [3:0]   awlen;
    logic         awvalid, awready;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    logic         wlast, wvalid, wready;
    logic         bvalid, bready, b_auto, b_man;
    logic [1:0]   bresp;

    int           errors = 0;
    int           checks = 0;
    int           popcnt [4];
    int           done_cnt [4];
    int           wlast_cnt = 0;
    int           gnt_seq [64];
    logic [5:0]   gnt_n = '0;

    always #5 clk = ~clk;

    assign bvalid = b_auto ? bready : b_man;

    rp_scope_axi_wr_arb dut (
        .axi_clk_i     (clk),
        .axi_rst_i     (rst),
        .req_i         (req),
        .req_addr_i    (addr_v),
        .req_len_i     (len_v),
        .gnt_o         (gnt),
        .ch_dat_i      (dat_v),
        .ch_strb_i     (strb_v),
        .ch_rd_o       (ch_rd),
        .done_o        (done),
        .err_o         (err),
        .busy_o        (busy),
        .axi_awaddr_o  (awaddr),
        .axi_awlen_o   (awlen),
        .axi_awvalid_o (awvalid),
        .axi_awready_i (awready),
        .axi_wdata_o   (wdata),
        .axi_wstrb_o   (wstrb),
        .axi_wlast_o   (wlast),
        .axi_wvalid_o  (wvalid),
        .axi_wready_i  (wready),
        .axi_bvalid_i  (bvalid),
        .axi_bresp_i   (bresp),
        .axi_bready_o  (bready)
    );

    // Channel buffer model: head word encodes channel and number of pops so far.
    always_comb begin
        dat_v  = '0;
        strb_v = '0;
        for (int c = 0; c < 4; c++) begin
            dat_v[c*64 +: 64] = {8'(160 + c), 56'(popcnt[c])};
            strb_v[c*8 +: 8]  = ~8'(popcnt[c]);
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (rst) popcnt[c] <= 0;
            else if (ch_rd[c]) popcnt[c] <= popcnt[c] + 1;
        end
    end

    function automatic int oh2idx(input logic [3:0] oh);
        oh2idx = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) oh2idx = i;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) if (done[c]) done_cnt[c] <= done_cnt[c] + 1;
            if (|gnt) begin
                gnt_seq[gnt_n] <= oh2idx(gnt);
                gnt_n          <= gnt_n + 6'd1;
            end
            if (wvalid && wready && wlast) wlast_cnt <= wlast_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [31:0] a, input logic [3:0] l);
        addr_v[c*32 +: 32] = a;
        len_v[c*4 +: 4]    = l;
        req[c]             = 1'b1;
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        req   = '0;
        b_man = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_until_quiet(input int max_cyc, output int used);
        used = 0;
        while (used < max_cyc) begin
            tick();
            used++;
            req = req & ~gnt;
            if (req == '0 && !awvalid && !wvalid && (!b_auto || !busy)) break;
        end
    endtask

    initial begin
        int         used, bad, dbad, lbad, beats, base_d, base_w;
        logic [5:0] base;
        int         exp2 [5] = '{0, 1, 2, 3, 0};
        int         exp4 [5] = '{0, 1, 0, 1, 0};

        rst = 1'b1; req = '0; addr_v = '0; len_v = '0;
        awready = 1'b0; wready = 1'b0; b_auto = 1'b0; b_man = 1'b0; bresp = 2'b00;
        for (int c = 0; c < 4; c++) done_cnt[c] = 0;
        repeat (3) tick();

        // reset state
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid",  64'(wvalid),  64'd0);
        check("rst_wlast",   64'(wlast),   64'd0);
        check("rst_bready",  64'(bready),  64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_pulses",  64'({gnt, ch_rd, done, err}), 64'd0);
        check("rst_awaddr",  64'(awaddr),  64'd0);
        check("rst_wdata",   64'(wdata),   64'd0);
        rst = 1'b0;

        // 1: single 16-beat burst on ch0
        set_req(0, 32'h1000_0000, 4'd15);
        awready = 1'b1; wready = 1'b1;
        tick();
        check("t1_awvalid", 64'(awvalid), 64'd1);
        check("t1_awaddr",  64'(awaddr),  64'h1000_0000);
        check("t1_awlen",   64'(awlen),   64'd15);
        check("t1_gnt",     64'(gnt),     64'b0001);
        req = '0;
        tick();
        dbad = 0; lbad = 0;
        for (int b = 0; b < 16; b++) begin
            if (!wvalid || ch_rd !== 4'b0001) dbad++;
            if (wdata !== {8'hA0, 56'(b)} || wstrb !== ~8'(b)) dbad++;
            if (wlast !== (b == 15)) lbad++;
            tick();
        end
        check("t1_beats",   64'(dbad), 64'd0);
        check("t1_wlast",   64'(lbad), 64'd0);
        check("t1_pops",    64'(popcnt[0]), 64'd16);
        check("t1_w_done",  64'(wvalid), 64'd0);
        check("t1_bready",  64'(bready), 64'd1);
        b_man = 1'b1; bresp = 2'b00;
        #1;
        check("t1_done",    64'({done, err}), 64'b0001_0000);
        tick();
        b_man = 1'b0;
        #1;
        check("t1_idle",    64'({bready, busy}), 64'd0);

        // 2: all channels requesting continuously
        reset_dut();
        for (int c = 0; c < 4; c++) set_req(c, 32'h4000_0000 + 32'(c) * 32'h1000, 4'd0);
        b_auto = 1'b1;
        base = gnt_n;
        for (int i = 0; i < 60 && 6'(gnt_n - base) < 6'd5; i++) tick();
        req = '0;
        run_until_quiet(100, used);
        check("t2_timeout", 64'(used < 100), 64'd1);
        for (int k = 0; k < 5; k++) check("t2_order", 64'(gnt_seq[6'(base + 6'(k))]), 64'(exp2[k]));
        check("t2_pops", 64'({8'(popcnt[0]), 8'(popcnt[1]), 8'(popcnt[2]), 8'(popcnt[3])}), 64'h02010101);

        // 3: AW stall then random W stalls
        reset_dut();
        b_auto = 1'b0; awready = 1'b0; wready = 1'b0;
        base_w = wlast_cnt;
        set_req(2, 32'h2000_0100, 4'd7);
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!awvalid || awaddr !== 32'h2000_0100 || awlen !== 4'd7 || gnt !== 4'd0) bad++;
            tick();
        end
        check("t3_aw_stable", 64'(bad), 64'd0);
        awready = 1'b1;
        #1;
        check("t3_gnt", 64'(gnt), 64'b0100);
        tick();
        req = '0; awready = 1'b0;
        beats = 0; dbad = 0; lbad = 0;
        for (int i = 0; i < 200 && beats < 8; i++) begin
            wready = 1'($urandom_range(0, 1));
            #1;
            if (wvalid && wlast !== (beats == 7)) lbad++;
            if (wvalid && wready) begin
                if (wdata !== {8'hA2, 56'(beats)}) dbad++;
                beats++;
            end
            tick();
        end
        wready = 1'b1;
        check("t3_beats",  64'(beats), 64'd8);
        check("t3_wdata",  64'(dbad), 64'd0);
        check("t3_wlast",  64'(lbad), 64'd0);
        check("t3_pops",   64'(popcnt[2]), 64'd8);
        check("t3_lastct", 64'(wlast_cnt - base_w), 64'd1);
        check("t3_wdone",  64'(wvalid), 64'd0);

        // 4: B withheld, fifth burst waits for a free slot
        reset_dut();
        awready = 1'b1; wready = 1'b1;
        set_req(0, 32'h5000_0000, 4'd0);
        set_req(1, 32'h5100_0000, 4'd0);
        base = gnt_n;
        repeat (40) tick();
        check("t4_issued", 64'(6'(gnt_n - base)), 64'd4);
        check("t4_hold",   64'({awvalid, bready, busy}), 64'b011);
        b_man = 1'b1; bresp = 2'b00;
        #1;
        check("t4_done",   64'(done), 64'b0001);
        tick();
        b_man = 1'b0;
        #1;
        check("t4_wait",   64'(awvalid), 64'd0);
        tick();
        check("t4_release", 64'({awvalid, gnt}), 64'b1_0001);
        req = '0; b_auto = 1'b1;
        run_until_quiet(100, used);
        check("t4_timeout", 64'(used < 100), 64'd1);
        for (int k = 0; k < 5; k++) check("t4_order", 64'(gnt_seq[6'(base + 6'(k))]), 64'(exp4[k]));

        // 5: SLVERR on second response
        reset_dut();
        b_auto = 1'b0;
        set_req(1, 32'h1100_0000, 4'd1);
        set_req(3, 32'h3300_0000, 4'd0);
        base = gnt_n;
        run_until_quiet(100, used);
        check("t5_timeout", 64'(used < 100), 64'd1);
        check("t5_order",   64'({8'(gnt_seq[base]), 8'(gnt_seq[6'(base + 6'd1)])}), 64'h0103);
        b_man = 1'b1; bresp = 2'b00;
        #1;
        check("t5_b1",      64'({done, err}), 64'b0010_0000);
        tick();
        bresp = 2'b10;
        #1;
        check("t5_b2",      64'({done, err, 3'b0, bready}), 64'b1000_1000_0001);
        tick();
        b_man = 1'b0; bresp = 2'b00;
        #1;
        check("t5_empty",   64'({bready, busy}), 64'd0);

        // 6: reset mid-burst, then a fresh burst
        reset_dut();
        b_auto = 1'b1; awready = 1'b1; wready = 1'b1;
        set_req(3, 32'h3000_0000, 4'd15);
        tick();
        req = '0;
        tick();
        repeat (7) tick();
        check("t6_beat7",  64'(wdata), {8'hA3, 56'd7});
        rst = 1'b1;
        tick();
        check("t6_abort",  64'({awvalid, wvalid, busy, bready}), 64'd0);
        rst = 1'b0;
        tick();
        base_d = done_cnt[3]; base_w = wlast_cnt;
        set_req(3, 32'h3000_0040, 4'd3);
        run_until_quiet(100, used);
        check("t6_timeout", 64'(used < 100), 64'd1);
        check("t6_pops",    64'(popcnt[3]), 64'd4);
        check("t6_done",    64'(done_cnt[3] - base_d), 64'd1);
        check("t6_wlast",   64'(wlast_cnt - base_w), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
